// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector element-address sequencer.
package vec_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} agu_state_e;

  // Index width for a power-of-two count; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Regfile element address {reg, elem}, i.e. reg*VLMAX + elem.
  function automatic logic [31:0] pack_addr(input logic [31:0] reg_idx,
                                            input logic [31:0] elem,
                                            input int          elem_w);
    return (reg_idx << elem_w) | elem;
  endfunction

endpackage

// File: rtl/vec_wb_delay.sv
// Fixed-depth shift register of {valid, elem} that aligns write-back with
// the registered regfile read plus the ALU pipeline.
module vec_wb_delay #(
  parameter int DEPTH  = 2,
  parameter int ELEM_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ELEM_W-1:0] in_elem,
  output logic              out_valid,
  output logic [ELEM_W-1:0] out_elem,
  output logic              pending
);

  logic [DEPTH-1:0]  valid_q;
  logic [ELEM_W-1:0] elem_q [DEPTH];

  // NOTE: sequential state uses <= so every stage samples its neighbour's
  // pre-edge value; blocking here would collapse the shift into one stage.
  // NOTE: the payload stages are reset too, so Ac reads 0 after reset
  // instead of stale element numbers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) elem_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      elem_q[0]  <= in_elem;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        elem_q[i]  <= elem_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_elem  = elem_q[DEPTH-1];

  // Any live entry still behind the one currently on the output.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) pending = pending | valid_q[i];
  end

endmodule

// File: rtl/vec_agu.sv
// Element-address sequencer: streams read pairs on ports A/B for one vector
// operation and emits the aligned write-back address on port C.
module vec_agu
  import vec_pkg::*;
#(
  parameter  int N_VEC   = 32,
  parameter  int VLMAX   = 32,
  parameter  int ALU_LAT = 1,
  localparam int REG_W   = idx_w(N_VEC),
  localparam int ELEM_W  = idx_w(VLMAX)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [REG_W-1:0]        cmd_vs1,
  input  logic [REG_W-1:0]        cmd_vs2,
  input  logic [REG_W-1:0]        cmd_vd,
  input  logic [ELEM_W:0]         cmd_vl,
  input  logic                    cmd_wr_en,
  output logic                    busy,
  output logic                    done,
  output logic [REG_W+ELEM_W-1:0] Aa,
  output logic [REG_W+ELEM_W-1:0] Ab,
  output logic [REG_W+ELEM_W-1:0] Ac,
  output logic                    req_validAddrA,
  output logic                    req_validAddrB,
  output logic                    req_validAddrC,
  output logic                    req_validDc
);

  localparam int ADDR_W = REG_W + ELEM_W;
  localparam int VL_W   = ELEM_W + 1;
  localparam int DEPTH  = 1 + ALU_LAT;
  localparam logic [VL_W-1:0] VL_MAX = VL_W'(VLMAX);

  agu_state_e        state_q, state_d;
  logic [REG_W-1:0]  vs1_q, vs2_q, vd_q;
  logic [VL_W-1:0]   vl_q;
  logic              wr_q;
  logic [ELEM_W-1:0] elem_q;
  logic              done_q;

  logic              accept, issue, last_elem;
  logic [VL_W-1:0]   eff_vl;
  logic              wb_valid, wb_pending;
  logic [ELEM_W-1:0] wb_elem;

  assign eff_vl    = (cmd_vl > VL_MAX) ? VL_MAX : cmd_vl;
  assign accept    = cmd_valid && (state_q == IDLE);
  assign issue     = (state_q == ISSUE);
  assign last_elem = ({1'b0, elem_q} == vl_q - VL_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vd_q    <= '0;
      vl_q    <= '0;
      wr_q    <= 1'b0;
      elem_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DRAIN) && (state_d == IDLE);
      if (accept) begin
        vs1_q  <= cmd_vs1;
        vs2_q  <= cmd_vs2;
        vd_q   <= cmd_vd;
        vl_q   <= eff_vl;
        wr_q   <= cmd_wr_en;
        elem_q <= '0;
      end else if (issue) begin
        elem_q <= elem_q + ELEM_W'(1);
      end
    end
  end

  // NOTE: state_d takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (eff_vl != '0) ? ISSUE : DRAIN;
      ISSUE:   if (last_elem) state_d = DRAIN;
      DRAIN:   if (!wb_pending) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The line tracks every issued element so the drain length does not depend
  // on wr_en; the write strobe is qualified by the latched wr_en at its output.
  vec_wb_delay #(
    .DEPTH  (DEPTH),
    .ELEM_W (ELEM_W)
  ) u_wb_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_elem   (elem_q),
    .out_valid (wb_valid),
    .out_elem  (wb_elem),
    .pending   (wb_pending)
  );

  always_comb begin
    cmd_ready      = (state_q == IDLE);
    busy           = (state_q != IDLE);
    done           = done_q;
    req_validAddrA = issue;
    req_validAddrB = issue;
    Aa = issue ? ADDR_W'(pack_addr(32'(vs1_q), 32'(elem_q), ELEM_W)) : '0;
    Ab = issue ? ADDR_W'(pack_addr(32'(vs2_q), 32'(elem_q), ELEM_W)) : '0;
    req_validAddrC = wb_valid && wr_q;
    req_validDc    = wb_valid && wr_q;
    Ac = (wb_valid && wr_q) ? ADDR_W'(pack_addr(32'(vd_q), 32'(wb_elem), ELEM_W)) : '0;
  end

endmodule

// File: tb/tb_vec_agu.sv
// Self-checking bench for vec_agu: table of commands with a cycle-stamped
// scoreboard of expected reads, writes and done pulses.
module tb_vec_agu;

  localparam int ALU_LAT = 1;
  localparam int VLMAX   = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [4:0] cmd_vs1 = '0, cmd_vs2 = '0, cmd_vd = '0;
  logic [5:0] cmd_vl = '0;
  logic       cmd_wr_en = 1'b0;
  logic       busy, done;
  logic [9:0] Aa, Ab, Ac;
  logic       req_validAddrA, req_validAddrB, req_validAddrC, req_validDc;

  vec_agu #(.N_VEC(32), .VLMAX(VLMAX), .ALU_LAT(ALU_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_vs1        (cmd_vs1),
    .cmd_vs2        (cmd_vs2),
    .cmd_vd         (cmd_vd),
    .cmd_vl         (cmd_vl),
    .cmd_wr_en      (cmd_wr_en),
    .busy           (busy),
    .done           (done),
    .Aa             (Aa),
    .Ab             (Ab),
    .Ac             (Ac),
    .req_validAddrA (req_validAddrA),
    .req_validAddrB (req_validAddrB),
    .req_validAddrC (req_validAddrC),
    .req_validDc    (req_validDc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [9:0] a;
    logic [9:0] b;
  } ev_t;

  typedef struct {
    int vs1, vs2, vd, vl;
    bit wr;
    int done_lat, n_rd, n_wr, last_aa, gap;
  } vec_t;

  ev_t  rd_q[$];
  ev_t  wr_q[$];
  int   done_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   rd_seen = 0, wr_seen = 0;
  int   stray_rd = 0, stray_wr = 0, stray_done = 0;
  logic [9:0] last_aa = '0;
  bit   mon_en = 1'b0;
  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (req_validAddrA || req_validAddrB) begin
        ev_t e;
        check("validB_eq_validA", 64'(req_validAddrB), 64'(req_validAddrA));
        rd_seen++;
        last_aa = Aa;
        if (rd_q.size() == 0) stray_rd++;
        else begin
          e = rd_q.pop_front();
          check("rd_cycle", 64'(cyc), 64'(e.cyc));
          check("Aa", 64'(Aa), 64'(e.a));
          check("Ab", 64'(Ab), 64'(e.b));
        end
      end
      if (req_validAddrC || req_validDc) begin
        ev_t e;
        check("validDc_eq_validC", 64'(req_validDc), 64'(req_validAddrC));
        wr_seen++;
        if (wr_q.size() == 0) stray_wr++;
        else begin
          e = wr_q.pop_front();
          check("wr_cycle", 64'(cyc), 64'(e.cyc));
          check("Ac", 64'(Ac), 64'(e.a));
        end
      end
      if (done) begin
        if (done_q.size() == 0) stray_done++;
        else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
    end
  end

  // Reference behaviour: element i read in c0+1+i, written in c0+i+2+ALU_LAT.
  task automatic push_model(input int c0, input vec_t v);
    int eff;
    eff = (v.vl > VLMAX) ? VLMAX : v.vl;
    for (int i = 0; i < eff; i++) begin
      rd_q.push_back('{c0 + 1 + i, 10'(v.vs1 * VLMAX + i), 10'(v.vs2 * VLMAX + i)});
      if (v.wr) wr_q.push_back('{c0 + i + 2 + ALU_LAT, 10'(v.vd * VLMAX + i), 10'd0});
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    cmd_vs1   = 5'(v.vs1);
    cmd_vs2   = 5'(v.vs2);
    cmd_vd    = 5'(v.vd);
    cmd_vl    = 6'(v.vl);
    cmd_wr_en = v.wr;
    cmd_valid = 1'b1;
  endtask

  // Drives in the current cycle; returns 1ns after the done falling edge so
  // a following call issues back-to-back in the done cycle.
  task automatic run_cmd(input vec_t v);
    int c0;
    bit got;
    c0 = cyc;
    rd_seen = 0;
    wr_seen = 0;
    drive_cmd(v);
    push_model(c0, v);
    done_q.push_back(c0 + v.done_lat);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_after_accept", 64'(busy), 64'd1);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(got), 64'd1);
    #1;
    if (!got) begin
      rd_q.delete();
      wr_q.delete();
      done_q.delete();
    end
    check("ready_in_done", 64'(cmd_ready), 64'd1);
    check("busy_in_done", 64'(busy), 64'd0);
    check("rd_count", 64'(rd_seen), 64'(v.n_rd));
    check("wr_count", 64'(wr_seen), 64'(v.n_wr));
    if (v.n_rd > 0) check("last_Aa", 64'(last_aa), 64'(v.last_aa));
    check("sb_empty", 64'(rd_q.size() + wr_q.size() + done_q.size()), 64'd0);
    if (v.gap > 0) begin
      repeat (v.gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_valids"},
          64'({req_validAddrA, req_validAddrB, req_validAddrC, req_validDc}), 64'd0);
    check({tag, "_addrs"}, 64'({Aa, Ab, Ac}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //        vs1 vs2 vd  vl  wr    done n_rd n_wr last_aa gap
    tbl[0] = '{2,  3,  4,  4,  1'b1, 7,   4,   4,   'h043,  0};
    tbl[1] = '{5,  6,  7,  0,  1'b1, 2,   0,   0,   0,      0};
    tbl[2] = '{1,  9,  10, 40, 1'b1, 35,  32,  32,  'h03F,  3};
    tbl[3] = '{8,  9,  8,  3,  1'b0, 6,   3,   0,   'h102,  0};
    tbl[4] = '{31, 0,  31, 1,  1'b1, 4,   1,   1,   'h3E0,  0};
    tbl[5] = '{0,  31, 5,  32, 1'b1, 35,  32,  32,  'h01F,  2};

    #12;
    check_idle("in_reset");
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("after_reset");
    mon_en = 1'b1;

    // Table entries with gap 0 are issued back-to-back in the done cycle.
    for (int i = 0; i < 6; i++) run_cmd(tbl[i]);

    // Reset in cycle 2 of a vl=8 command: strobes drop, nothing follows.
    v = '{3, 4, 5, 8, 1'b1, 0, 0, 0, 0, 0};
    drive_cmd(v);
    push_model(cyc, v);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    check("rd_before_abort", 64'(req_validAddrA), 64'd1);
    rst = 1'b0;
    #1;
    check("abort_valids",
          64'({req_validAddrA, req_validAddrB, req_validAddrC, req_validDc}), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(cmd_ready), 64'd1);
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("stray_rd", 64'(stray_rd), 64'd0);
    check("stray_wr", 64'(stray_wr), 64'd0);
    check("stray_done", 64'(stray_done), 64'd0);

    // Recovery after the abort, then a back-to-back pair.
    run_cmd(tbl[0]);
    run_cmd(tbl[4]);
    check("final_stray", 64'(stray_rd + stray_wr + stray_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
